gate_count_module: RTL
======================

GATE_COUNT_MODULE -- requirements
Module: gate_count_module

Interface
REQ-001 The block SHALL provide parameter CLK_FREQ_HZ, default 50000000: clk frequency; the gate window is CLK_FREQ_HZ cycles (1 s).
REQ-002 The block SHALL provide parameter DIV_SHIFT, default 4: log2 of the upstream prescale ratio (16).
REQ-003 The block SHALL provide parameter CNT_W, default 32: edge-counter and result width.
REQ-004 Port: clk  input  1  system clock; all state is clocked on posedge clk.
REQ-005 Port: rst  input  1  reset, asynchronous and active-high.
REQ-006 Port: en  input  1  measurement enable; level-sensitive.
REQ-007 Port: signal_in1  input  1  prescaled measured signal, asynchronous to clk.
REQ-008 Port: freq_hz  output  CNT_W  last completed result in Hz.
REQ-009 Port: freq_valid  output  1  one-cycle pulse when freq_hz updates.
REQ-010 Port: busy  output  1  high while a gate window is open.
REQ-011 Port: overflow  output  1  result saturated; present only with GATE_CNT_OVERFLOW_EN.

Function
REQ-012 signal_in1 SHALL pass through a 2-flop synchronizer; a rising edge is detected from flop2 high and a third delay flop low.
REQ-013 FSM states SHALL be IDLE, GATE and LATCH.
REQ-014 IDLE->GATE when en=1: clear edge counter and gate timer to 0, assert busy.
REQ-015 In GATE, the timer increments every cycle and each detected edge increments the edge counter by 1.
REQ-016 GATE->LATCH on the cycle the timer equals CLK_FREQ_HZ-1; an edge detected on that cycle SHALL be counted.
REQ-017 In LATCH, freq_hz <= edge_count << DIV_SHIFT (truncated to CNT_W), freq_valid=1 for exactly that cycle, busy=0.
REQ-018 LATCH->GATE if en=1, otherwise LATCH->IDLE; back-to-back windows lose exactly one clk cycle (LATCH).
REQ-019 en=0 during GATE SHALL abort to IDLE on the next cycle: no freq_valid, freq_hz keeps its previous value.
REQ-020 An edge detected in the LATCH cycle SHALL be discarded.
REQ-021 Measurement latency from the last counted edge to freq_valid SHALL be 2-4 clk cycles (synchronizer plus LATCH).

Reset
REQ-022 rst=1 SHALL asynchronously force: FSM=IDLE; counters, synchronizer flops, freq_hz and freq_valid=0; busy=0; overflow=0.
REQ-023 rst asserted mid-window SHALL discard the window; measurement restarts from IDLE after release.

Configuration
REQ-024 With GATE_CNT_OVERFLOW_EN defined, the edge counter SHALL saturate at (2^CNT_W-1)>>DIV_SHIFT.
REQ-025 With GATE_CNT_OVERFLOW_EN defined, overflow SHALL be updated in LATCH alongside freq_hz (1 if saturation was reached).
REQ-026 Without GATE_CNT_OVERFLOW_EN, the overflow port SHALL be absent and the counter wraps modulo 2^CNT_W.

Structure
REQ-027 Package freq_meter_pkg SHALL hold the FSM state enum (IDLE/GATE/LATCH) and the default constants for CLK_FREQ_HZ, DIV_SHIFT and CNT_W.
REQ-028 The synchronizer plus edge detector SHALL be sub-module edge_sync_module (inputs clk, rst, d; output rise pulse).

Verification (CLK_FREQ_HZ=1000, DIV_SHIFT=4, CNT_W=32)
REQ-029 en=1, signal_in1 period 10 clk -> freq_valid 1000-1001 cycles after en; freq_hz=1600; busy low only in the LATCH cycle.
REQ-030 en held high, period 10 then 20 clk at the window boundary -> successive results 1600 then 800, one freq_valid per window.
REQ-031 Edge timed so the synchronized edge lands on the final gate cycle -> counted (edge_count 100, not 99); an edge landing in LATCH -> excluded from both windows.
REQ-032 en dropped at gate cycle 500 -> no freq_valid, freq_hz unchanged, busy=0 next cycle; rst pulsed mid-window -> all outputs 0 immediately.
REQ-033 With GATE_CNT_OVERFLOW_EN and CNT_W=8, 20 edges in the window -> freq_hz=240 (15<<4), overflow=1; without the macro -> freq_hz=64 (20<<4 truncated to 8 bits), no overflow port.
REQ-034 signal_in1 held constant for a full window -> freq_hz=0, freq_valid pulses once.

Source files
------------

// File: rtl/freq_meter_pkg.sv
// freq_meter_pkg: shared FSM state type and default constants for the gated frequency counter.
// Rev 1.0
`default_nettype none

package freq_meter_pkg;

  localparam int DEF_CLK_FREQ_HZ = 50_000_000;
  localparam int DEF_DIV_SHIFT   = 4;
  localparam int DEF_CNT_W       = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GATE  = 2'd1,
    LATCH = 2'd2
  } state_t;

  // Gate timer width; a one-cycle window still needs a 1-bit timer.
  function automatic int timer_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/edge_sync_module.sv
// edge_sync_module: 2-flop synchronizer plus delay flop; emits a one-cycle pulse per rising edge.
// Rev 1.0
`default_nettype none

module edge_sync_module (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic r_ff1;
  logic r_ff2;
  logic r_ff3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ff1 <= 1'b0;
      r_ff2 <= 1'b0;
      r_ff3 <= 1'b0;
    end else begin
      r_ff1 <= d;
      r_ff2 <= r_ff1;
      r_ff3 <= r_ff2;
    end
  end

  assign rise = r_ff2 & ~r_ff3;

endmodule

`default_nettype wire

// File: rtl/gate_count_module.sv
// gate_count_module: counts prescaled edges over a CLK_FREQ_HZ-cycle gate and reports Hz. Rev 1.0
// Optional: GATE_CNT_OVERFLOW_EN adds a saturating edge counter and the overflow output.
`default_nettype none

module gate_count_module
  import freq_meter_pkg::*;
#(
  parameter int CLK_FREQ_HZ = DEF_CLK_FREQ_HZ,
  parameter int DIV_SHIFT   = DEF_DIV_SHIFT,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             signal_in1,
  output logic [CNT_W-1:0] freq_hz,
  output logic             freq_valid,
`ifdef GATE_CNT_OVERFLOW_EN
  output logic             overflow,
`endif
  output logic             busy
);

  localparam int               TMR_W    = timer_width(CLK_FREQ_HZ);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CLK_FREQ_HZ - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [TMR_W-1:0] r_timer;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [CNT_W-1:0] r_freq_hz;
  logic             r_freq_valid;
  logic             w_rise;
  logic             w_last;

  edge_sync_module u_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (signal_in1),
    .rise (w_rise)
  );

`ifdef GATE_CNT_OVERFLOW_EN
  // Saturation point keeps the shifted result from wrapping.
  localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}} >> DIV_SHIFT;
  logic r_ovf;

  assign w_cnt_inc = (r_cnt == CNT_SAT) ? r_cnt : r_cnt + CNT_W'(1);
  assign overflow  = r_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (r_state == LATCH) begin
      r_ovf <= (r_cnt == CNT_SAT);
    end
  end
`else
  assign w_cnt_inc = r_cnt + CNT_W'(1);
`endif

  assign w_last = (r_timer == TMR_LAST);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (en) w_state_nxt = GATE;
      GATE: begin
        if (!en)         w_state_nxt = IDLE;
        else if (w_last) w_state_nxt = LATCH;
      end
      LATCH:   w_state_nxt = en ? GATE : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_timer      <= '0;
      r_cnt        <= '0;
      r_freq_hz    <= '0;
      r_freq_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_freq_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (en) begin
            r_timer <= '0;
            r_cnt   <= '0;
          end
        end
        GATE: begin
          r_timer <= r_timer + TMR_W'(1);
          if (w_rise) r_cnt <= w_cnt_inc;
        end
        LATCH: begin
          // Edges arriving in this cycle are dropped by the counter clear.
          r_freq_hz    <= r_cnt << DIV_SHIFT;
          r_freq_valid <= 1'b1;
          r_timer      <= '0;
          r_cnt        <= '0;
        end
        default: begin
          r_timer <= '0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign freq_hz    = r_freq_hz;
  assign freq_valid = r_freq_valid;
  assign busy       = (r_state == GATE);

endmodule

`default_nettype wire
